// File: rtl/palindrome_arbiter_if.sv
// Requester/response bundle for palindrome_arbiter.
// Purely structural: no logic, no latency.
// Backpressure: req_ready gates each requester, rsp_ready stalls the response.
interface palindrome_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          rsp_valid;
    logic                          rsp_ready;
    logic [ID_WIDTH-1:0]           rsp_id;
    logic [DATA_WIDTH-1:0]         rsp_data;
    logic                          rsp_detect;

    // Drives requests and accepts responses (sources and collector side).
    modport master (
        output req_valid, req_data, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_detect
    );

    // The arbiter itself.
    modport slave (
        input  req_valid, req_data, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data, rsp_detect
    );
endinterface

// File: rtl/palindrome_arbiter.sv
// Round-robin arbiter sharing one registered bit-palindrome check among NUM_REQ requesters.
// Latency: accept edge T -> rsp_valid after edge T+1; one word per 3 cycles at best.
// Backpressure: no req_ready outside IDLE; response held until rsp_ready. Optional counters: PAL_ARB_STATS_EN.
module palindrome_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    palindrome_arbiter_if.slave  bus,
    output logic                 busy
`ifdef PAL_ARB_STATS_EN
    ,
    output logic [15:0]          hit_count,
    output logic [15:0]          req_count
`endif
);

    typedef enum logic [1:0] {IDLE, CHECK, RESP} state_t;

    state_t                  state_q, state_d;
    logic [ID_WIDTH-1:0]     last_grant_q, last_grant_d;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic                    detect_q, detect_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic                    busy_q, busy_d;

    logic                    gnt_found;
    logic [ID_WIDTH-1:0]     gnt_idx;
    logic                    accept;
    logic [NUM_REQ-1:0]      req_ready_c;
    logic                    pal_c;
    int                      cand;

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = (int'(last_grant_q) + off) % NUM_REQ;
            if (!gnt_found && bus.req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = ID_WIDTH'(cand);
            end
        end
    end

    // Accept only in IDLE; suppressed while reset is asserted so no phantom strobe is seen.
    always_comb begin
        accept      = (state_q == IDLE) && gnt_found && !rst;
        req_ready_c = '0;
        if (accept) begin
            req_ready_c[gnt_idx] = 1'b1;
        end
    end

    // Mirror-pair compare; the middle bit of an odd width has no partner and is skipped.
    always_comb begin
        pal_c = 1'b1;
        for (int i = 0; i < DATA_WIDTH / 2; i++) begin
            pal_c = pal_c & ~(word_q[i] ^ word_q[DATA_WIDTH-1-i]);
        end
    end

    // Next-state and next-output computation for the IDLE -> CHECK -> RESP loop.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        id_d         = id_q;
        word_d       = word_q;
        detect_d     = detect_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    word_d       = bus.req_data[int'(gnt_idx)*DATA_WIDTH +: DATA_WIDTH];
                    id_d         = gnt_idx;
                    last_grant_d = gnt_idx;
                    state_d      = CHECK;
                end
            end
            CHECK: begin
                detect_d = pal_c;
                state_d  = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        rsp_valid_d = (state_d == RESP);
        busy_d      = (state_d != IDLE);
    end

    // State and registered outputs; reset discards any in-flight word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            last_grant_q <= ID_WIDTH'(NUM_REQ - 1);
            id_q         <= '0;
            word_q       <= '0;
            detect_q     <= 1'b0;
            rsp_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            id_q         <= id_d;
            word_q       <= word_d;
            detect_q     <= detect_d;
            rsp_valid_q  <= rsp_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = word_q;
    assign bus.rsp_detect = detect_q;
    assign busy           = busy_q;

`ifdef PAL_ARB_STATS_EN
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] req_count_q, req_count_d;

    // Saturating counters: accepts, and completed responses that were palindromes.
    always_comb begin
        req_count_d = req_count_q;
        hit_count_d = hit_count_q;
        if (accept && req_count_q != 16'hFFFF) begin
            req_count_d = req_count_q + 16'd1;
        end
        if (rsp_valid_q && bus.rsp_ready && detect_q && hit_count_q != 16'hFFFF) begin
            hit_count_d = hit_count_q + 16'd1;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_count_q <= '0;
            hit_count_q <= '0;
        end else begin
            req_count_q <= req_count_d;
            hit_count_q <= hit_count_d;
        end
    end

    assign hit_count = hit_count_q;
    assign req_count = req_count_q;
`endif

endmodule

// File: tb/tb_palindrome_arbiter.sv
// Randomized and directed bench for palindrome_arbiter against a transaction-level model.
// Inputs change 1ns after the rising edge; outputs are compared on the falling edge.
// The collector's rsp_ready is toggled to exercise response stalls.
module tb_palindrome_arbiter;
    localparam int DW = 8;
    localparam int NR = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;
    logic [NR-1:0]         tb_valid = '0;
    logic [NR-1:0][DW-1:0] tb_data  = '0;
    logic                  tb_rsp_ready = 1'b1;
`ifdef PAL_ARB_STATS_EN
    logic [15:0] hit_count, req_count;
`endif

    always #5 clk = ~clk;

    palindrome_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) bus ();

    assign bus.req_valid = tb_valid;
    assign bus.req_data  = tb_data;
    assign bus.rsp_ready = tb_rsp_ready;

    palindrome_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ID_WIDTH(IW)) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
`ifdef PAL_ARB_STATS_EN
        ,
        .hit_count (hit_count),
        .req_count (req_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: one outstanding job plus the arbitration pointer.
    bit             m_pend = 0;
    int             m_age  = 0;
    int             m_ptr  = NR - 1;
    int             m_id   = 0;
    logic [DW-1:0]  m_data = '0;
    bit             m_det  = 0;
    int             m_gnt  = -1;
    int             m_reqs = 0;
    int             m_hits = 0;
    bit             refill = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // A word is a bit-palindrome exactly when it equals its own bit reversal.
    function automatic bit is_pal(input logic [DW-1:0] w);
        logic [DW-1:0] r;
        r = {<<{w}};
        return w == r;
    endfunction

    function automatic logic [DW-1:0] gen_word();
        logic [DW-1:0] w;
        w = DW'($urandom);
        case ($urandom % 4)
            0: for (int i = 0; i < DW / 2; i++) w[DW-1-i] = w[i];
            1: w = ($urandom % 2) ? '1 : '0;
            default: ;
        endcase
        return w;
    endfunction

    task automatic model_reset();
        m_pend = 0; m_age = 0; m_ptr = NR - 1;
        m_reqs = 0; m_hits = 0;
    endtask

    // Compare this cycle's outputs with the model, then advance the model across the next edge.
    task automatic step();
        int g;
        logic [NR-1:0] er;
        @(negedge clk);
        g = -1;
        if (!m_pend) begin
            for (int o = 1; o <= NR; o++) begin
                int c;
                c = (m_ptr + o) % NR;
                if (g < 0 && tb_valid[c]) g = c;
            end
        end
        er = '0;
        if (g >= 0 && !rst) er[g] = 1'b1;
        chk("req_ready", 64'(bus.req_ready), 64'(er));
        chk("rsp_valid", 64'(bus.rsp_valid), 64'(m_pend && m_age >= 1));
        chk("busy", 64'(busy), 64'(m_pend));
        if (m_pend && m_age >= 1) begin
            chk("rsp_id", 64'(bus.rsp_id), 64'(m_id));
            chk("rsp_data", 64'(bus.rsp_data), 64'(m_data));
            chk("rsp_detect", 64'(bus.rsp_detect), 64'(m_det));
        end
`ifdef PAL_ARB_STATS_EN
        chk("req_count", 64'(req_count), 64'(m_reqs));
        chk("hit_count", 64'(hit_count), 64'(m_hits));
`endif
        m_gnt = -1;
        if (rst) begin
            model_reset();
        end else if (m_pend) begin
            if (m_age >= 1 && tb_rsp_ready) begin
                m_pend = 0;
                if (m_det && m_hits < 65535) m_hits++;
            end else if (m_age < 2) begin
                m_age++;
            end
        end else if (g >= 0) begin
            m_pend = 1; m_age = 0; m_id = g;
            m_data = tb_data[g]; m_det = is_pal(tb_data[g]);
            m_ptr = g; m_gnt = g;
            if (m_reqs < 65535) m_reqs++;
        end
        @(posedge clk);
        #1;
    endtask

    // Granted requester either drops valid or, in refill mode, presents a fresh word.
    task automatic cyc(input int n);
        repeat (n) begin
            step();
            if (m_gnt >= 0) begin
                if (refill) tb_data[m_gnt] = gen_word();
                else tb_valid[m_gnt] = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        chk("reset_rsp_id", 64'(bus.rsp_id), 64'd0);
        chk("reset_rsp_data", 64'(bus.rsp_data), 64'd0);
        chk("reset_rsp_detect", 64'(bus.rsp_detect), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);

        // Lone requester 2 with a palindrome.
        tb_data[2] = 8'h99; tb_valid = 4'b0100; tb_rsp_ready = 1'b1;
        cyc(5);

        // Requester 1 with the collector stalled for several cycles.
        tb_data[1] = 8'hA5; tb_valid = 4'b0010; tb_rsp_ready = 1'b0;
        cyc(7);
        tb_rsp_ready = 1'b1;
        cyc(3);

        // Everyone valid continuously: strict rotation, one response per 3 cycles.
        refill = 1;
        for (int k = 0; k < NR; k++) tb_data[k] = gen_word();
        tb_valid = '1;
        cyc(24);
        refill = 0;
        tb_valid = '0;
        cyc(4);

        // Non-palindrome on 3, palindrome on 0, presented together.
        tb_data[3] = 8'h01; tb_data[0] = 8'h81; tb_valid = 4'b1001;
        cyc(8);

        // Reset while requester 1's word is in CHECK; requester 0 must win afterwards.
        tb_data[1] = 8'h3C; tb_valid = 4'b0010;
        cyc(1);
        rst = 1'b1; tb_valid = 4'b0011; tb_data[0] = 8'hE7;
        cyc(1);
        rst = 1'b0;
        cyc(1);
        chk("post_reset_grant0", 64'(m_id), 64'd0);
        tb_valid = '0;
        cyc(6);

        // Three words after a reset: two palindromes, one not.
        rst = 1'b1; cyc(1); rst = 1'b0;
        tb_data[0] = 8'h81; tb_valid = 4'b0001; cyc(4);
        tb_data[1] = 8'h01; tb_valid = 4'b0010; cyc(4);
        tb_data[2] = 8'hFF; tb_valid = 4'b0100; cyc(4);
`ifdef PAL_ARB_STATS_EN
        chk("stats_req_count", 64'(req_count), 64'd3);
        chk("stats_hit_count", 64'(hit_count), 64'd2);
`endif

        // Random traffic with stalls, drops, re-assertions and the odd reset.
        for (int n = 0; n < 3000; n++) begin
            tb_rsp_ready = ($urandom % 10) < 7;
            rst = ($urandom % 400) == 0;
            step();
            for (int k = 0; k < NR; k++) begin
                if (tb_valid[k]) begin
                    if (k == m_gnt) begin
                        if ($urandom % 2) tb_data[k] = gen_word();
                        else tb_valid[k] = 1'b0;
                    end else if ($urandom % 25 == 0) begin
                        tb_valid[k] = 1'b0;
                    end
                end else if ($urandom % 3 == 0) begin
                    tb_valid[k] = 1'b1;
                    tb_data[k] = gen_word();
                end
            end
        end
        rst = 1'b0;
        tb_valid = '0;
        tb_rsp_ready = 1'b1;
        cyc(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
